// File: rtl/cache_set_if.sv
// cache_set_if: request/response bundle between the cache controller and one
// 8-way cache set.
//   master (controller): drives set_enable, write_enable, block_offset,
//                        write_data, write_size, tag; receives the rest.
//   slave  (cache_set) : receives the request, drives n_ops, out_data,
//                        set_miss_w, set_miss_r, data_ready.
interface cache_set_if;
  logic [1:0]   set_enable;
  logic [1:0]   write_enable;
  logic [5:0]   block_offset;
  logic [63:0]  write_data;
  logic [2:0]   write_size;
  logic [23:0]  tag;
  logic [31:0]  n_ops;
  logic [127:0] out_data;
  logic [1:0]   set_miss_w;
  logic [1:0]   set_miss_r;
  logic [1:0]   data_ready;

  modport master (
    output set_enable, write_enable, block_offset, write_data, write_size, tag,
    input  n_ops, out_data, set_miss_w, set_miss_r, data_ready
  );

  modport slave (
    input  set_enable, write_enable, block_offset, write_data, write_size, tag,
    output n_ops, out_data, set_miss_w, set_miss_r, data_ready
  );
endinterface

// File: rtl/cache_set.sv
// cache_set: one 8-way set of the L1 data cache. Holds data/tag/valid/dirty
// for 8 lines of 64 bytes, does tag compare, byte-granular read (16 bytes,
// wrapping) and write (1/2/4/8 bytes, clipped at the line end), and picks a
// victim on write misses (write-allocate, zero-filled line). Results are
// registered: flags and read data appear one cycle after the accepting edge.
// Ports: clk, rst (sync, active high), bus (cache_set_if.slave).
// Build option: SET_LRU_EN selects true-LRU victim choice; without it a
// round-robin pointer names the victim. Invalid ways are always used first.
module cache_set #(
  parameter int WAYS        = 8,
  parameter int BLOCK_BYTES = 64,
  parameter int TAG_W       = 24
) (
  input  logic        clk,
  input  logic        rst,
  cache_set_if.slave  bus
);

  typedef logic [BLOCK_BYTES-1:0][7:0] line_t;

  line_t            data_q [WAYS];
  logic [TAG_W-1:0] tag_q  [WAYS];
  logic [WAYS-1:0]  valid_q, dirty_q;

  logic         rdy_q, miss_r_q, miss_w_q;
  logic [31:0]  ops_q;
  logic [127:0] out_q;

  logic req, wr;
  assign req = bus.set_enable[0];
  assign wr  = bus.write_enable[0];

  // Upper request bits are don't-care; dirty is held for the controller's
  // writeback path and is not exported from this block.
  logic unused_bits;
  assign unused_bits = ^{bus.set_enable[1], bus.write_enable[1], dirty_q};

  // Tag match and lowest-index invalid way (scan high->low so low wins).
  logic       hit, any_inv;
  logic [2:0] hit_way, inv_way, victim, tgt;
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    any_inv = 1'b0;
    inv_way = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        any_inv = 1'b1;
        inv_way = 3'(i);
      end
      if (valid_q[i] && tag_q[i] == bus.tag) begin
        hit     = 1'b1;
        hit_way = 3'(i);
      end
    end
  end

`ifdef SET_LRU_EN
  logic [WAYS-1:0][2:0] age_q;
  logic [2:0]           lru_way;
  always_comb begin
    lru_way = '0;
    for (int i = 0; i < WAYS; i++)
      if (age_q[i] == 3'd7) lru_way = 3'(i);
  end
  assign victim = any_inv ? inv_way : lru_way;
`else
  logic [2:0] rr_q;
  assign victim = any_inv ? inv_way : rr_q;
`endif

  assign tgt = hit ? hit_way : victim;

  // Write path: start from the hit line (or zeros on allocate), overlay bytes.
  logic [3:0] nbytes;
  line_t      new_line;
  logic [6:0] pos;
  always_comb begin
    case (bus.write_size)
      3'd0:    nbytes = 4'd1;
      3'd1:    nbytes = 4'd2;
      3'd2:    nbytes = 4'd4;
      default: nbytes = 4'd8;
    endcase
    new_line = hit ? data_q[hit_way] : '0;
    pos      = '0;
    for (int k = 0; k < 8; k++) begin
      pos = {1'b0, bus.block_offset} + 7'(k);
      // no wrap on writes: bytes beyond the line end are dropped
      if (4'(k) < nbytes && pos < 7'(BLOCK_BYTES))
        new_line[pos[5:0]] = bus.write_data[8*k +: 8];
    end
  end

  // Read path: 16 bytes, offset wraps naturally in the 6-bit sum.
  logic [127:0] rd_data;
  always_comb begin
    rd_data = '0;
    for (int k = 0; k < 16; k++)
      rd_data[8*k +: 8] = data_q[hit_way][6'(bus.block_offset + 6'(k))];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q  <= '0;
      dirty_q  <= '0;
      out_q    <= '0;
      rdy_q    <= 1'b0;
      miss_r_q <= 1'b0;
      miss_w_q <= 1'b0;
      ops_q    <= '0;
    end else begin
      rdy_q    <= 1'b0;
      miss_r_q <= 1'b0;
      miss_w_q <= 1'b0;
      if (req) begin
        ops_q <= ops_q + 32'd1;
        if (wr) begin
          miss_w_q      <= !hit;
          valid_q[tgt]  <= 1'b1;
          dirty_q[tgt]  <= 1'b1;
        end else if (hit) begin
          out_q <= rd_data;
          rdy_q <= 1'b1;
        end else begin
          out_q    <= '0;
          miss_r_q <= 1'b1;
        end
      end
    end
  end

  // Data and tag arrays carry no reset; valid bits gate their use.
  always_ff @(posedge clk) begin
    if (!rst && req && wr) begin
      data_q[tgt] <= new_line;
      tag_q[tgt]  <= bus.tag;
    end
  end

`ifdef SET_LRU_EN
  // Touch: ages younger than the touched way step up, touched way -> 0.
  // This keeps the ages a permutation of 0..7, so exactly one way is 7.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < WAYS; i++) age_q[i] <= 3'(i);
    end else if (req && (wr || hit)) begin
      for (int i = 0; i < WAYS; i++) begin
        if (3'(i) == tgt)             age_q[i] <= 3'd0;
        else if (age_q[i] < age_q[tgt]) age_q[i] <= age_q[i] + 3'd1;
      end
    end
  end
`else
  always_ff @(posedge clk) begin
    if (rst)                                rr_q <= '0;
    else if (req && wr && !hit && !any_inv) rr_q <= rr_q + 3'd1;
  end
`endif

  assign bus.n_ops      = ops_q;
  assign bus.out_data   = out_q;
  assign bus.data_ready = {1'b0, rdy_q};
  assign bus.set_miss_r = {1'b0, miss_r_q};
  assign bus.set_miss_w = {1'b0, miss_w_q};

endmodule

// File: tb/tb_cache_set.sv
// tb_cache_set: self-checking bench for cache_set. A behavioural model keeps
// the set as byte arrays, a recency-ordered list of ways (front = most recent)
// and a round-robin index, and predicts every registered output.
module tb_cache_set;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cache_set_if bus();
  cache_set dut (.clk(clk), .rst(rst), .bus(bus));

  int n_pass = 0;
  int n_total = 0;

  // reference model
  logic [7:0]  mdata [8][64];
  logic [23:0] mtag  [8];
  bit          mvalid[8];
  int          order[$];
  int          rr;
  logic [31:0]  exp_ops;
  logic [127:0] exp_out;
  bit e_rdy, e_mr, e_mw;

  wire [165:0] act_vec = {bus.data_ready, bus.set_miss_r, bus.set_miss_w,
                          bus.n_ops, bus.out_data};

  function automatic logic [165:0] exp_vec();
    return {1'b0, e_rdy, 1'b0, e_mr, 1'b0, e_mw, exp_ops, exp_out};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) mvalid[i] = 1'b0;
    order = {};
    for (int i = 0; i < 8; i++) order.push_back(i);
    rr = 0; exp_ops = '0; exp_out = '0;
    e_rdy = 0; e_mr = 0; e_mw = 0;
  endtask

  task automatic model_touch(input int w);
    for (int i = 0; i < order.size(); i++)
      if (order[i] == w) begin order.delete(i); break; end
    order.push_front(w);
  endtask

  task automatic model_access(input bit we, input int off, input logic [63:0] wd,
                              input int sz, input logic [23:0] tg);
    int h, w, n;
    exp_ops = exp_ops + 1;
    e_rdy = 0; e_mr = 0; e_mw = 0;
    h = -1;
    for (int i = 0; i < 8; i++) if (mvalid[i] && mtag[i] == tg) h = i;
    if (!we) begin
      if (h >= 0) begin
        for (int k = 0; k < 16; k++) exp_out[8*k +: 8] = mdata[h][(off + k) % 64];
        e_rdy = 1;
        model_touch(h);
      end else begin
        exp_out = '0;
        e_mr = 1;
      end
    end else begin
      if (h < 0) begin
        e_mw = 1;
        w = -1;
        for (int i = 7; i >= 0; i--) if (!mvalid[i]) w = i;
        if (w < 0) begin
`ifdef SET_LRU_EN
          w = order[$];
`else
          w = rr; rr = (rr + 1) % 8;
`endif
        end
        for (int b = 0; b < 64; b++) mdata[w][b] = 8'h00;
        mtag[w] = tg; mvalid[w] = 1'b1;
      end else w = h;
      n = (sz >= 3) ? 8 : (1 << sz);
      for (int k = 0; k < n; k++)
        if (off + k < 64) mdata[w][off + k] = wd[8*k +: 8];
      model_touch(w);
    end
  endtask

  // Drive one request (inputs set #1 after an edge), advance one edge.
  task automatic drive(input bit we, input int off, input logic [63:0] wd,
                       input int sz, input logic [23:0] tg);
    bus.set_enable   = {1'($urandom), 1'b1};
    bus.write_enable = {1'($urandom), we};
    bus.block_offset = 6'(off);
    bus.write_data   = wd;
    bus.write_size   = 3'(sz);
    bus.tag          = tg;
    model_access(we, off, wd, sz, tg);
    @(posedge clk); #1;
    bus.set_enable   = {1'($urandom), 1'b0};
  endtask

  task automatic idle();
    bus.set_enable = {1'($urandom), 1'b0};
    e_rdy = 0; e_mr = 0; e_mw = 0;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    bus.set_enable = 2'b00; bus.write_enable = 2'b00; bus.block_offset = '0;
    bus.write_data = '0; bus.write_size = '0; bus.tag = '0;
    repeat (2) @(posedge clk);
    #1; rst = 1'b0;
    model_reset();
    n_total++;
    if (act_vec !== 166'd0) $display("FAIL reset_state: got %h want 0", act_vec);
    else n_pass++;
  endtask

  task automatic test_directed();
    drive(0, 0, 64'h0, 0, 24'h000ABC);
    n_total++;
    if (act_vec !== exp_vec() || bus.set_miss_r !== 2'b01 || bus.data_ready !== 2'b00 ||
        bus.out_data !== 128'd0 || bus.n_ops !== 32'd1)
      $display("FAIL first_read_miss: got %h want %h", act_vec, exp_vec());
    else n_pass++;

    drive(1, 8, 64'h1122334455667788, 3, 24'h000ABC);
    n_total++;
    if (act_vec !== exp_vec() || bus.set_miss_w !== 2'b01)
      $display("FAIL write_alloc: got %h want %h", act_vec, exp_vec());
    else n_pass++;

    drive(0, 8, 64'h0, 0, 24'h000ABC);
    n_total++;
    if (act_vec !== exp_vec() || bus.data_ready !== 2'b01 ||
        bus.out_data !== {64'h0, 64'h1122334455667788})
      $display("FAIL read_hit: got %h want %h", act_vec, exp_vec());
    else n_pass++;

    drive(1, 62, 64'hDDCCBBAA, 2, 24'h000ABC);
    n_total++;
    if (act_vec !== exp_vec() || bus.set_miss_w !== 2'b00)
      $display("FAIL write_clip: got %h want %h", act_vec, exp_vec());
    else n_pass++;

    drive(0, 56, 64'h0, 0, 24'h000ABC);
    n_total++;
    if (act_vec !== exp_vec() || bus.out_data !== {64'h0, 64'hBBAA_0000_0000_0000})
      $display("FAIL read_wrap: got %h want %h", act_vec, exp_vec());
    else n_pass++;

    drive(0, 4, 64'h0, 0, 24'h000ABC);
    n_total++;
    if (act_vec !== exp_vec() || bus.out_data[95:32] !== 64'h1122334455667788)
      $display("FAIL read_mid: got %h want %h", act_vec, exp_vec());
    else n_pass++;

    // pulse drops after an idle cycle, data holds
    idle();
    n_total++;
    if (act_vec !== exp_vec() || bus.data_ready !== 2'b00)
      $display("FAIL pulse_idle: got %h want %h", act_vec, exp_vec());
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    drive(1, 10, 64'hBEEF, 1, 24'h000ABC);
    drive(0, 8, 64'h0, 0, 24'h000ABC);
    n_total++;
    if (act_vec !== exp_vec() || bus.out_data[31:16] !== 16'hBEEF)
      $display("FAIL back_to_back: got %h want %h", act_vec, exp_vec());
    else n_pass++;
  endtask

  task automatic test_eviction();
    do_reset();
    for (int i = 0; i < 9; i++) drive(1, 0, 64'(i + 1), 3, 24'h100 + 24'(i));
    drive(0, 0, 64'h0, 0, 24'h100);
    n_total++;
    if (act_vec !== exp_vec() || bus.set_miss_r !== 2'b01)
      $display("FAIL evict_t0: got %h want %h", act_vec, exp_vec());
    else n_pass++;
    drive(0, 0, 64'h0, 0, 24'h101);
    n_total++;
    if (act_vec !== exp_vec() || bus.data_ready !== 2'b01 || bus.out_data !== 128'd2)
      $display("FAIL keep_t1: got %h want %h", act_vec, exp_vec());
    else n_pass++;

    do_reset();
    for (int i = 0; i < 8; i++) drive(1, 0, 64'(i + 1), 3, 24'h100 + 24'(i));
    drive(0, 0, 64'h0, 0, 24'h100);
    drive(1, 0, 64'h9, 3, 24'h108);
    drive(0, 0, 64'h0, 0, 24'h100);
    n_total++;
`ifdef SET_LRU_EN
    if (act_vec !== exp_vec() || bus.data_ready !== 2'b01 || bus.out_data !== 128'd1)
`else
    if (act_vec !== exp_vec() || bus.set_miss_r !== 2'b01)
`endif
      $display("FAIL evict_after_touch_t0: got %h want %h", act_vec, exp_vec());
    else n_pass++;
    drive(0, 0, 64'h0, 0, 24'h101);
    n_total++;
`ifdef SET_LRU_EN
    if (act_vec !== exp_vec() || bus.set_miss_r !== 2'b01)
`else
    if (act_vec !== exp_vec() || bus.data_ready !== 2'b01)
`endif
      $display("FAIL evict_after_touch_t1: got %h want %h", act_vec, exp_vec());
    else n_pass++;
  endtask

  task automatic test_reset_with_write();
    bus.set_enable = 2'b01; bus.write_enable = 2'b01; bus.block_offset = 6'd0;
    bus.write_data = 64'hFFFF; bus.write_size = 3'd3; bus.tag = 24'h000ABC;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.set_enable = 2'b00;
    model_reset();
    n_total++;
    if (act_vec !== 166'd0) $display("FAIL reset_vs_write: got %h want 0", act_vec);
    else n_pass++;
    drive(0, 0, 64'h0, 0, 24'h000ABC);
    n_total++;
    if (act_vec !== exp_vec() || bus.set_miss_r !== 2'b01 || bus.n_ops !== 32'd1)
      $display("FAIL reset_read_miss: got %h want %h", act_vec, exp_vec());
    else n_pass++;
    drive(0, 0, 64'h0, 0, 24'h101);
    n_total++;
    if (act_vec !== exp_vec() || bus.set_miss_r !== 2'b01)
      $display("FAIL reset_read_miss2: got %h want %h", act_vec, exp_vec());
    else n_pass++;
  endtask

  task automatic test_random();
    int errs = 0;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 99) < 15) idle();
      else drive($urandom_range(0, 1) == 1, int'($urandom_range(0, 63)),
                 {$urandom, $urandom}, int'($urandom_range(0, 7)),
                 24'h200 + 24'($urandom_range(0, 11)));
      n_total++;
      if (act_vec !== exp_vec()) begin
        if (errs < 10) $display("FAIL random_%0d: got %h want %h", n, act_vec, exp_vec());
        errs++;
      end else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_eviction();
    test_reset_with_write();
    do_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
